load_issue_scheduler: RTL and testbench

//   Circular load queue plus issue scheduler for the out-of-order LSU. Holds in-flight loads by ROB tag,

---
 rtl/load_issue_scheduler.sv | 230 +++++++++++++++++++++++
 tb/tb_load_issue_scheduler.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_issue_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : load_issue_scheduler
// Purpose  : Circular load queue with an oldest-first issue scheduler for the
//            out-of-order LSU. Loads are allocated at the tail by dispatch,
//            receive their effective address from the AGU, and are issued one
//            at a time onto the single data-memory port. The oldest
//            address-ready, unissued load wins. Age is the ROB-tag distance
//            from the ROB head. Entries retire from the head on commit.
// Ports    : clk_i, reset_i           clock / synchronous active-high reset
//            alloc_valid_i, alloc_rob_tag_i, alloc_ready_o, alloc_idx_o
//                                      dispatch allocation at the tail
//            addr_valid_i, addr_idx_i, addr_i
//                                      AGU address delivery
//            rob_head_i                ROB head tag, the age reference
//            mem_req_valid_o, mem_req_addr_o, mem_req_rob_tag_o,
//            mem_req_ready_i, mem_resp_valid_i
//                                      memory port, one request outstanding
//            commit_valid_i, head_done_o
//                                      in-order retirement
//            flush_i                   squash the whole queue
// Revision : 1.0 - initial release
// ============================================================================
module load_issue_scheduler #(
  parameter  int LQ_SIZE       = 8,
  parameter  int ROB_TAG_WIDTH = 5,
  parameter  int XLEN          = 32,
  localparam int IDX_W         = $clog2(LQ_SIZE)
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     alloc_valid_i,
  input  logic [ROB_TAG_WIDTH-1:0] alloc_rob_tag_i,
  output logic                     alloc_ready_o,
  output logic [IDX_W-1:0]         alloc_idx_o,
  input  logic                     addr_valid_i,
  input  logic [IDX_W-1:0]         addr_idx_i,
  input  logic [XLEN-1:0]          addr_i,
  input  logic [ROB_TAG_WIDTH-1:0] rob_head_i,
  output logic                     mem_req_valid_o,
  output logic [XLEN-1:0]          mem_req_addr_o,
  output logic [ROB_TAG_WIDTH-1:0] mem_req_rob_tag_o,
  input  logic                     mem_req_ready_i,
  input  logic                     mem_resp_valid_i,
  input  logic                     commit_valid_i,
  input  logic                     flush_i,
  output logic                     head_done_o
);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_REQ   = 2'd1;
  localparam logic [1:0] c_WAIT  = 2'd2;
  localparam logic [1:0] c_DRAIN = 2'd3;

  // Per-entry storage
  logic [LQ_SIZE-1:0]       valid_q;
  logic [LQ_SIZE-1:0]       addr_ok_q;
  logic [LQ_SIZE-1:0]       issued_q;
  logic [LQ_SIZE-1:0]       done_q;
  logic [ROB_TAG_WIDTH-1:0] tag_q  [LQ_SIZE];
  logic [XLEN-1:0]          addr_q [LQ_SIZE];

  logic [IDX_W-1:0]         head_q;
  logic [IDX_W-1:0]         tail_q;
  logic [IDX_W:0]           count_q;
  logic [IDX_W:0]           count_d;

  logic [1:0]               state_q;
  logic [1:0]               state_d;

  // Outstanding request, latched at issue
  logic [XLEN-1:0]          req_addr_q;
  logic [ROB_TAG_WIDTH-1:0] req_tag_q;
  logic [IDX_W-1:0]         req_idx_q;

  logic [LQ_SIZE-1:0]       w_elig;
  logic                     w_any_elig;
  logic [IDX_W-1:0]         w_sel_idx;
  logic [ROB_TAG_WIDTH-1:0] w_sel_age;
  logic [ROB_TAG_WIDTH-1:0] w_age;
  logic                     w_alloc_fire;
  logic                     w_commit_fire;
  logic                     w_handshake;
  logic                     w_issue;
  logic                     w_resp_done;

  assign alloc_ready_o     = (count_q < (IDX_W+1)'(LQ_SIZE));
  assign alloc_idx_o       = tail_q;
  assign head_done_o       = valid_q[head_q] & done_q[head_q];
  assign mem_req_addr_o    = req_addr_q;
  assign mem_req_rob_tag_o = req_tag_q;

  assign w_elig        = valid_q & addr_ok_q & ~issued_q;
  assign w_alloc_fire  = alloc_valid_i & alloc_ready_o;
  assign w_commit_fire = commit_valid_i & head_done_o;
  assign w_handshake   = mem_req_valid_o & mem_req_ready_i;
  assign w_issue       = (state_q == c_IDLE) & w_any_elig & ~flush_i;
  assign w_resp_done   = (state_q == c_WAIT) & mem_resp_valid_i & ~flush_i;

  // Oldest-eligible pick. Age is the unsigned modular distance of the tag
  // from the ROB head, so tags that wrapped past zero still sort correctly.
  always_comb begin
    w_any_elig = 1'b0;
    w_sel_idx  = '0;
    w_sel_age  = '0;
    w_age      = '0;
    for (int i = 0; i < LQ_SIZE; i++) begin
      w_age = tag_q[i] - rob_head_i;
      if (w_elig[i] && (!w_any_elig || (w_age < w_sel_age))) begin
        w_any_elig = 1'b1;
        w_sel_idx  = IDX_W'(i);
        w_sel_age  = w_age;
      end
    end
  end

  always_comb begin
    count_d = count_q;
    if (w_alloc_fire && !w_commit_fire) begin
      count_d = count_q + 1'b1;
    end else if (!w_alloc_fire && w_commit_fire) begin
      count_d = count_q - 1'b1;
    end
  end

  // FSM: state register
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= c_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state. A request the memory already accepted must have its
  // response swallowed after a flush, hence DRAIN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      c_IDLE: begin
        if (w_issue) state_d = c_REQ;
      end
      c_REQ: begin
        if (flush_i) begin
          state_d = w_handshake ? c_DRAIN : c_IDLE;
        end else if (w_handshake) begin
          state_d = c_WAIT;
        end
      end
      c_WAIT: begin
        if (mem_resp_valid_i) begin
          state_d = c_IDLE;
        end else if (flush_i) begin
          state_d = c_DRAIN;
        end
      end
      c_DRAIN: begin
        if (mem_resp_valid_i) state_d = c_IDLE;
      end
      default: state_d = c_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    mem_req_valid_o = (state_q == c_REQ);
  end

  // Queue storage and pointers
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      valid_q    <= '0;
      addr_ok_q  <= '0;
      issued_q   <= '0;
      done_q     <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      req_addr_q <= '0;
      req_tag_q  <= '0;
      req_idx_q  <= '0;
    end else begin
      if (w_issue) begin
        req_addr_q <= addr_q[w_sel_idx];
        req_tag_q  <= tag_q[w_sel_idx];
        req_idx_q  <= w_sel_idx;
      end
      if (flush_i) begin
        valid_q   <= '0;
        addr_ok_q <= '0;
        issued_q  <= '0;
        done_q    <= '0;
        head_q    <= '0;
        tail_q    <= '0;
        count_q   <= '0;
      end else begin
        count_q <= count_d;
        if (w_issue) begin
          issued_q[w_sel_idx] <= 1'b1;
        end
        if (w_resp_done) begin
          done_q[req_idx_q] <= 1'b1;
        end
        if (addr_valid_i && valid_q[addr_idx_i]) begin
          addr_q[addr_idx_i]    <= addr_i;
          addr_ok_q[addr_idx_i] <= 1'b1;
        end
        if (w_alloc_fire) begin
          valid_q[tail_q]   <= 1'b1;
          tag_q[tail_q]     <= alloc_rob_tag_i;
          addr_ok_q[tail_q] <= 1'b0;
          issued_q[tail_q]  <= 1'b0;
          done_q[tail_q]    <= 1'b0;
          tail_q            <= tail_q + 1'b1;
        end
        // Written last so a retiring head is cleared even if the AGU
        // targets it in the same cycle.
        if (w_commit_fire) begin
          valid_q[head_q]   <= 1'b0;
          addr_ok_q[head_q] <= 1'b0;
          issued_q[head_q]  <= 1'b0;
          done_q[head_q]    <= 1'b0;
          head_q            <= head_q + 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_load_issue_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_load_issue_scheduler
// Purpose  : Self-checking bench for load_issue_scheduler. A program-order
//            queue model predicts every memory request into a scoreboard;
//            a negedge monitor pops and compares on each accepted request
//            and cross-checks the status outputs every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_load_issue_scheduler;

  localparam int LQ = 8;
  localparam int TW = 5;
  localparam int XL = 32;
  localparam int IW = 3;

  localparam int P_IDLE  = 0;
  localparam int P_REQ   = 1;
  localparam int P_WAIT  = 2;
  localparam int P_DRAIN = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          alloc_valid = 1'b0;
  logic [TW-1:0] alloc_rob_tag = '0;
  logic          alloc_ready;
  logic [IW-1:0] alloc_idx;
  logic          addr_valid = 1'b0;
  logic [IW-1:0] addr_idx = '0;
  logic [XL-1:0] addr = '0;
  logic [TW-1:0] rob_head = '0;
  logic          mem_req_valid;
  logic [XL-1:0] mem_req_addr;
  logic [TW-1:0] mem_req_rob_tag;
  logic          mem_req_ready = 1'b0;
  logic          mem_resp_valid = 1'b0;
  logic          commit_valid = 1'b0;
  logic          flush = 1'b0;
  logic          head_done;

  load_issue_scheduler #(.LQ_SIZE(LQ), .ROB_TAG_WIDTH(TW), .XLEN(XL)) dut (
    .clk_i             (clk),
    .reset_i           (reset),
    .alloc_valid_i     (alloc_valid),
    .alloc_rob_tag_i   (alloc_rob_tag),
    .alloc_ready_o     (alloc_ready),
    .alloc_idx_o       (alloc_idx),
    .addr_valid_i      (addr_valid),
    .addr_idx_i        (addr_idx),
    .addr_i            (addr),
    .rob_head_i        (rob_head),
    .mem_req_valid_o   (mem_req_valid),
    .mem_req_addr_o    (mem_req_addr),
    .mem_req_rob_tag_o (mem_req_rob_tag),
    .mem_req_ready_i   (mem_req_ready),
    .mem_resp_valid_i  (mem_resp_valid),
    .commit_valid_i    (commit_valid),
    .flush_i           (flush),
    .head_done_o       (head_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [TW-1:0] tag;
    logic [XL-1:0] addr;
    logic          aok;
    logic          iss;
    logic          done;
  } ent_t;

  typedef struct packed {
    logic [XL-1:0] addr;
    logic [TW-1:0] tag;
  } req_t;

  // Reference model: loads kept in program order, oldest at index 0
  ent_t          lq[$];
  req_t          expq[$];
  int            m_head = 0;
  int            m_phase = P_IDLE;
  logic [TW-1:0] m_out_tag = '0;
  logic [XL-1:0] m_req_addr = '0;
  logic [TW-1:0] m_req_tag = '0;
  bit            m_acc = 1'b0;
  bit            mon_en = 1'b0;
  logic [TW-1:0] next_tag = '0;

  int n_tests = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  // Advance the model by one clock using the inputs applied for that edge.
  task automatic model_step();
    int            pre_size;
    bit            pre_hd;
    bit            hs;
    int            best;
    int            pos;
    logic [TW-1:0] best_age;
    logic [TW-1:0] age;
    ent_t          e;
    req_t          r;
    m_acc    = 1'b0;
    pre_size = lq.size();
    pre_hd   = (pre_size > 0) && lq[0].done;
    hs       = (m_phase == P_REQ) && mem_req_ready;
    if (reset) begin
      lq.delete();
      expq.delete();
      m_head     = 0;
      m_phase    = P_IDLE;
      m_req_addr = '0;
      m_req_tag  = '0;
      return;
    end
    if (flush) begin
      case (m_phase)
        P_REQ: begin
          if (hs) begin
            m_phase = P_DRAIN;
          end else begin
            m_phase = P_IDLE;
            if (expq.size() > 0) expq.delete(expq.size() - 1);
          end
        end
        P_WAIT, P_DRAIN: m_phase = mem_resp_valid ? P_IDLE : P_DRAIN;
        default: m_phase = P_IDLE;
      endcase
      lq.delete();
      m_head = 0;
      return;
    end
    case (m_phase)
      P_IDLE: begin
        best = -1;
        best_age = '0;
        for (int i = 0; i < pre_size; i++) begin
          if (lq[i].aok && !lq[i].iss) begin
            age = lq[i].tag - rob_head;
            if (best < 0 || age < best_age) begin
              best = i;
              best_age = age;
            end
          end
        end
        if (best >= 0) begin
          e = lq[best];
          e.iss = 1'b1;
          lq[best] = e;
          m_req_addr = e.addr;
          m_req_tag = e.tag;
          m_out_tag = e.tag;
          r.addr = e.addr;
          r.tag = e.tag;
          expq.push_back(r);
          m_phase = P_REQ;
        end
      end
      P_REQ: if (hs) m_phase = P_WAIT;
      P_WAIT: begin
        if (mem_resp_valid) begin
          for (int i = 0; i < pre_size; i++) begin
            if (lq[i].tag == m_out_tag && lq[i].iss) begin
              e = lq[i];
              e.done = 1'b1;
              lq[i] = e;
            end
          end
          m_phase = P_IDLE;
        end
      end
      default: if (mem_resp_valid) m_phase = P_IDLE;
    endcase
    if (addr_valid) begin
      pos = (int'(addr_idx) - m_head + LQ) % LQ;
      if (pos < pre_size) begin
        e = lq[pos];
        e.addr = addr;
        e.aok = 1'b1;
        lq[pos] = e;
      end
    end
    if (alloc_valid && pre_size < LQ) begin
      e.tag = alloc_rob_tag;
      e.addr = '0;
      e.aok = 1'b0;
      e.iss = 1'b0;
      e.done = 1'b0;
      lq.push_back(e);
      m_acc = 1'b1;
    end
    if (commit_valid && pre_hd) begin
      lq.delete(0);
      m_head = (m_head + 1) % LQ;
    end
  endtask

  task automatic set_idle();
    reset = 1'b0;
    alloc_valid = 1'b0;
    addr_valid = 1'b0;
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b0;
    commit_valid = 1'b0;
    flush = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    if (m_acc) next_tag = next_tag + TW'(1 + ($urandom % 3));
    #1;
    set_idle();
  endtask

  task automatic do_alloc(input logic [TW-1:0] t);
    alloc_valid = 1'b1;
    alloc_rob_tag = t;
  endtask

  task automatic do_addr(input int idx, input logic [XL-1:0] a);
    addr_valid = 1'b1;
    addr_idx = IW'(idx);
    addr = a;
  endtask

  // Monitor: scoreboard pop on every accepted request plus status checks
  always @(negedge clk) begin
    req_t r;
    if (mon_en) begin
      chk("req_valid", 64'(mem_req_valid), 64'(m_phase == P_REQ));
      chk("req_addr", 64'(mem_req_addr), 64'(m_req_addr));
      chk("req_tag", 64'(mem_req_rob_tag), 64'(m_req_tag));
      chk("alloc_ready", 64'(alloc_ready), 64'(lq.size() < LQ));
      chk("alloc_idx", 64'(alloc_idx), 64'((m_head + lq.size()) % LQ));
      chk("head_done", 64'(head_done), 64'((lq.size() > 0) && lq[0].done));
      if (mem_req_valid && mem_req_ready) begin
        if (expq.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL sb_accept: request tag %0h accepted, expected none", mem_req_rob_tag);
        end else begin
          r = expq.pop_front();
          chk("sb_addr", 64'(mem_req_addr), 64'(r.addr));
          chk("sb_tag", 64'(mem_req_rob_tag), 64'(r.tag));
        end
      end
    end
  end

  initial begin
    // Reset state
    tick();
    mon_en = 1'b1;
    chk("rst_req_valid", 64'(mem_req_valid), 64'(0));
    chk("rst_req_addr", 64'(mem_req_addr), 64'(0));
    chk("rst_req_tag", 64'(mem_req_rob_tag), 64'(0));
    chk("rst_alloc_ready", 64'(alloc_ready), 64'(1));
    chk("rst_alloc_idx", 64'(alloc_idx), 64'(0));
    chk("rst_head_done", 64'(head_done), 64'(0));

    // Only-eligible load issues first, then the older one
    rob_head = 5'd0;
    do_alloc(5'd3); tick();
    do_alloc(5'd4); tick();
    do_alloc(5'd5); tick();
    do_addr(2, 32'h0000_2222); tick();
    do_addr(0, 32'h0000_0000); tick();
    chk("d1_first_valid", 64'(mem_req_valid), 64'(1));
    chk("d1_first_tag", 64'(mem_req_rob_tag), 64'(5));
    chk("d1_first_addr", 64'(mem_req_addr), 64'(32'h0000_2222));
    mem_req_ready = 1'b1; tick();
    chk("d1_wait_valid", 64'(mem_req_valid), 64'(0));
    mem_resp_valid = 1'b1; tick();
    tick();
    chk("d1_second_tag", 64'(mem_req_rob_tag), 64'(3));
    mem_req_ready = 1'b1; tick();
    mem_resp_valid = 1'b1; tick();
    chk("d1_head_done", 64'(head_done), 64'(1));
    commit_valid = 1'b1; tick();
    chk("d1_after_commit", 64'(head_done), 64'(0));
    flush = 1'b1; tick();

    // Age wrap: rob_head 30, tag 31 (age 1) beats tag 1 (age 3);
    // also holds a request under backpressure for 4 cycles
    rob_head = 5'd30;
    do_alloc(5'd29); tick();
    do_alloc(5'd31); do_addr(0, 32'hAAAA_0029); tick();
    do_alloc(5'd1); tick();
    for (int k = 0; k < 4; k++) begin
      if (k == 0) do_addr(2, 32'hAAAA_0001);
      if (k == 1) do_addr(1, 32'hAAAA_0031);
      chk("d2_hold_valid", 64'(mem_req_valid), 64'(1));
      chk("d2_hold_tag", 64'(mem_req_rob_tag), 64'(29));
      chk("d2_hold_addr", 64'(mem_req_addr), 64'(32'hAAAA_0029));
      tick();
    end
    mem_req_ready = 1'b1; tick();
    chk("d2_single_accept", 64'(mem_req_valid), 64'(0));
    mem_resp_valid = 1'b1; tick();
    tick();
    chk("d2_wrap_tag", 64'(mem_req_rob_tag), 64'(31));
    mem_req_ready = 1'b1; tick();
    mem_resp_valid = 1'b1; tick();
    tick();
    chk("d2_last_tag", 64'(mem_req_rob_tag), 64'(1));
    mem_req_ready = 1'b1; tick();
    mem_resp_valid = 1'b1; tick();
    flush = 1'b1; tick();

    // Full queue, alloc+commit at count 7
    rob_head = 5'd10;
    for (int k = 0; k < 8; k++) begin
      do_alloc(TW'(10 + k)); tick();
    end
    chk("d3_full", 64'(alloc_ready), 64'(0));
    do_addr(0, 32'h0000_1000); tick();
    tick();
    mem_req_ready = 1'b1; tick();
    mem_resp_valid = 1'b1; tick();
    commit_valid = 1'b1; tick();
    chk("d3_count7", 64'(alloc_ready), 64'(1));
    do_addr(1, 32'h0000_1001); tick();
    tick();
    mem_req_ready = 1'b1; tick();
    mem_resp_valid = 1'b1; tick();
    do_alloc(5'd18); commit_valid = 1'b1; tick();
    chk("d3_alloc_commit", 64'(alloc_ready), 64'(1));
    do_alloc(5'd19); tick();
    chk("d3_full_again", 64'(alloc_ready), 64'(0));

    // Reset while waiting for a response
    do_addr(2, 32'h0000_1002); tick();
    tick();
    mem_req_ready = 1'b1; tick();
    reset = 1'b1; tick();
    chk("d5_valid", 64'(mem_req_valid), 64'(0));
    chk("d5_alloc_ready", 64'(alloc_ready), 64'(1));
    chk("d5_head_done", 64'(head_done), 64'(0));
    chk("d5_alloc_idx", 64'(alloc_idx), 64'(0));

    // Flush in the handshake cycle -> drain the orphaned response
    rob_head = 5'd0;
    do_alloc(5'd2); tick();
    do_addr(0, 32'h0000_0BAD); tick();
    tick();
    mem_req_ready = 1'b1; flush = 1'b1; tick();
    chk("d4_valid", 64'(mem_req_valid), 64'(0));
    chk("d4_alloc_idx", 64'(alloc_idx), 64'(0));
    do_alloc(5'd9); tick();
    do_addr(0, 32'h0000_0009); tick();
    mem_resp_valid = 1'b1; tick();
    chk("d4_drained", 64'(head_done), 64'(0));
    tick();
    chk("d4_reissue_tag", 64'(mem_req_rob_tag), 64'(9));
    mem_req_ready = 1'b1; tick();
    mem_resp_valid = 1'b1; tick();
    chk("d4_done", 64'(head_done), 64'(1));

    // Randomized traffic
    reset = 1'b1; tick();
    next_tag = TW'($urandom);
    for (int c = 0; c < 3000; c++) begin
      alloc_valid = (($urandom % 3) == 0);
      alloc_rob_tag = next_tag;
      addr_valid = (($urandom % 2) == 0);
      addr_idx = IW'($urandom % LQ);
      addr = $urandom;
      commit_valid = (($urandom % 5) < 2);
      flush = (($urandom % 50) == 0);
      reset = (($urandom % 300) == 0);
      mem_req_ready = (($urandom % 5) < 3);
      if (m_phase == P_WAIT || m_phase == P_DRAIN) mem_resp_valid = (($urandom % 2) == 0);
      else mem_resp_valid = (($urandom % 20) == 0);
      if (lq.size() > 0 && ($urandom % 10) < 7) rob_head = lq[0].tag - TW'($urandom % 3);
      else rob_head = TW'($urandom);
      tick();
    end

    // Quiesce and confirm nothing predicted was left unserved
    flush = 1'b1; tick();
    for (int k = 0; k < 3; k++) begin
      mem_resp_valid = 1'b1; tick();
    end
    chk("end_scoreboard_empty", 64'(expq.size()), 64'(0));
    chk("end_req_valid", 64'(mem_req_valid), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
